// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider: terminal pulse, near-50% divided clock and live count,
// continuous or one-shot, with double-buffered divisor. Optional macro PROG_CLK_DIV_DUTY_EN adds duty_in.
module prog_clk_div #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PROG_CLK_DIV_DUTY_EN
  input  logic [WIDTH-1:0] duty_in,
`endif
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             pulse,
  output logic             clkout,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             div_err,
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_H = DEF_D >> 1;

  logic [WIDTH-1:0] r_count, r_d, r_shadow;
  logic             r_pending, r_armed, r_mode;
  logic             r_pulse, r_clkout, r_busy, r_div_err;
  logic [WIDTH-1:0] w_count_nx, w_d_nx, w_thr_nx;
  logic             w_mode, w_run, w_wrap, w_apply, w_trig, w_load_ok;
  logic             w_armed_nx, w_busy_nx;
`ifdef PROG_CLK_DIV_DUTY_EN
  logic [WIDTH-1:0] r_hth, r_hshadow;
`endif

  always_comb begin
    // Mode is only sampled at count 0, so a change mid-period waits for the wrap.
    w_mode  = (r_count == '0) ? mode : r_mode;
    w_run   = en && (!w_mode || r_armed);
    // >= rather than == keeps the count inside the period if a smaller divisor lands while idle.
    w_wrap  = w_run && (r_count >= r_d - ONE);
    w_apply = r_pending && (w_wrap || !w_run);
    w_trig  = start && w_mode && !r_armed;

    w_count_nx = r_count;
    w_armed_nx = r_armed && w_mode;
    if (w_trig) begin
      w_count_nx = '0;
      w_armed_nx = 1'b1;
    end else if (w_wrap) begin
      w_count_nx = '0;
      if (w_mode) w_armed_nx = 1'b0;
    end else if (w_run) begin
      w_count_nx = r_count + ONE;
    end

    w_d_nx = w_apply ? r_shadow : r_d;
`ifdef PROG_CLK_DIV_DUTY_EN
    w_thr_nx  = w_apply ? r_hshadow : r_hth;
    w_load_ok = div_load && (div_in >= TWO) && (duty_in < div_in);
`else
    w_thr_nx  = w_d_nx >> 1;
    w_load_ok = div_load && (div_in >= TWO);
`endif
    w_busy_nx = en && (!((w_count_nx == '0) ? mode : w_mode) || w_armed_nx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_d       <= DEF_D;
      r_shadow  <= DEF_D;
      r_pending <= 1'b0;
      r_armed   <= 1'b0;
      r_mode    <= 1'b0;
      r_pulse   <= 1'b0;
      r_clkout  <= 1'b0;
      r_busy    <= 1'b0;
      r_div_err <= 1'b0;
`ifdef PROG_CLK_DIV_DUTY_EN
      r_hth     <= DEF_H;
      r_hshadow <= DEF_H;
`endif
    end else begin
      r_count <= w_count_nx;
      r_armed <= w_armed_nx;
      r_mode  <= w_mode;
      r_d     <= w_d_nx;
      // A load on the apply edge wins: the old shadow goes live, the new one stays pending.
      if (w_load_ok) begin
        r_shadow  <= div_in;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      r_div_err <= div_load && !w_load_ok;
      r_busy    <= w_busy_nx;
      r_pulse   <= w_busy_nx && (w_count_nx == w_d_nx - ONE);
      r_clkout  <= (w_count_nx >= w_thr_nx);
`ifdef PROG_CLK_DIV_DUTY_EN
      r_hth <= w_thr_nx;
      if (w_load_ok) r_hshadow <= duty_in;
`endif
    end
  end

  assign count   = r_count;
  assign pulse   = r_pulse;
  assign clkout  = r_clkout;
  assign busy    = r_busy;
  assign div_err = r_div_err;
  assign clk_out = clk;

`ifndef PROG_CLK_DIV_DUTY_EN
  logic w_unused;
  assign w_unused = ^DEF_H;
`endif

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: directed vector table, hand sequences for reset/one-shot/mode change,
// and a randomized run against a behavioural period model.
module tb_prog_clk_div;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b0, en = 1'b0, mode = 1'b0, start = 1'b0, div_load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         pulse, clkout, busy, div_err, clk_out;
  logic [W-1:0] count;
`ifdef PROG_CLK_DIV_DUTY_EN
  logic [W-1:0] duty_in;
  int           duty_force = -1;
  always_comb duty_in = (duty_force >= 0) ? W'(duty_force) : (div_in >> 1);
`endif

  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  prog_clk_div #(.WIDTH(W), .DEFAULT_DIV(6)) dut (
    .clk(clk), .rst(rst),
`ifdef PROG_CLK_DIV_DUTY_EN
    .duty_in(duty_in),
`endif
    .en(en), .mode(mode), .start(start), .div_in(div_in), .div_load(div_load),
    .pulse(pulse), .clkout(clkout), .count(count), .busy(busy), .div_err(div_err),
    .clk_out(clk_out)
  );

  typedef struct {
    bit en, md, st, ld;
    int din;
    int cnt;
    bit p, c, b, e;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t vr(input int cnt, input bit p, input bit c);
    vec_t v;
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 0, cnt, p, c, 1'b1, 1'b0};
    return v;
  endfunction

  function automatic vec_t vx(input bit e_i, input bit ld, input int din,
                              input int cnt, input bit p, input bit c, input bit b, input bit e);
    vec_t v;
    v = '{e_i, 1'b0, 1'b0, ld, din, cnt, p, c, b, e};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(input bit e, input bit m, input bit s, input bit l, input logic [W-1:0] dv);
    en = e; mode = m; start = s; div_load = l; div_in = dv;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; div_load = 1'b0; div_in = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Behavioural model: a period of D cycles, divisor swapped only between periods.
  int m_cnt, m_d, m_sh;
  bit m_pend, m_armed, m_mode;
  bit e_pulse, e_clk, e_busy, e_err;

  task automatic model_reset();
    m_cnt = 0; m_d = 6; m_sh = 6; m_pend = 0; m_armed = 0; m_mode = 0;
  endtask

  task automatic model_step(input bit i_en, input bit i_mode, input bit i_start,
                            input bit i_ld, input int i_div);
    bit eff_mode, run, at_end, trig, nxt_mode;
    eff_mode = (m_cnt == 0) ? i_mode : m_mode;
    run      = i_en && (!eff_mode || m_armed);
    at_end   = run && (m_cnt + 1 >= m_d);
    trig     = i_start && eff_mode && !m_armed;
    if (m_pend && (at_end || !run)) begin
      m_d = m_sh;
      m_pend = 0;
    end
    if (i_ld && i_div >= 2) begin
      m_sh = i_div;
      m_pend = 1;
    end
    if (!eff_mode) m_armed = 0;
    if (trig) begin
      m_cnt = 0;
      m_armed = 1;
    end else if (run) begin
      m_cnt = at_end ? 0 : m_cnt + 1;
      if (at_end && eff_mode) m_armed = 0;
    end
    m_mode   = eff_mode;
    nxt_mode = (m_cnt == 0) ? i_mode : m_mode;
    e_busy   = i_en && (!nxt_mode || m_armed);
    e_pulse  = e_busy && (m_cnt == m_d - 1);
    e_clk    = (m_cnt >= m_d / 2);
    e_err    = i_ld && (i_div < 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int npulse;
    bit rmode;

    // Continuous run, divisor loads, rejected loads, holds, last-wins and load-at-wrap.
    for (int k = 1; k <= 5; k++) tbl.push_back(vr(k, k == 5, k >= 3));
    tbl.push_back(vr(0, 0, 0));
    tbl.push_back(vr(1, 0, 0));
    tbl.push_back(vr(2, 0, 0));
    tbl.push_back(vx(1, 1, 4, 3, 0, 1, 1, 0));
    tbl.push_back(vr(4, 0, 1));
    tbl.push_back(vr(5, 1, 1));
    tbl.push_back(vr(0, 0, 0));
    tbl.push_back(vr(1, 0, 0));
    tbl.push_back(vr(2, 0, 1));
    tbl.push_back(vr(3, 1, 1));
    tbl.push_back(vr(0, 0, 0));
    tbl.push_back(vx(1, 1, 1, 1, 0, 0, 1, 1));
    tbl.push_back(vx(1, 1, 0, 2, 0, 1, 1, 1));
    tbl.push_back(vr(3, 1, 1));
    tbl.push_back(vr(0, 0, 0));
    tbl.push_back(vr(1, 0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(vx(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(vr(2, 0, 1));
    tbl.push_back(vr(3, 1, 1));
    tbl.push_back(vx(0, 0, 0, 3, 0, 1, 0, 0));
    tbl.push_back(vr(0, 0, 0));
    tbl.push_back(vr(1, 0, 0));
    tbl.push_back(vx(1, 1, 7, 2, 0, 1, 1, 0));
    tbl.push_back(vx(1, 1, 3, 3, 1, 1, 1, 0));
    tbl.push_back(vr(0, 0, 0));
    tbl.push_back(vr(1, 0, 1));
    tbl.push_back(vr(2, 1, 1));
    tbl.push_back(vr(0, 0, 0));
    tbl.push_back(vx(1, 1, 5, 1, 0, 1, 1, 0));
    tbl.push_back(vr(2, 1, 1));
    tbl.push_back(vx(1, 1, 8, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 4; k++) tbl.push_back(vr(k, k == 4, k >= 2));
    tbl.push_back(vr(0, 0, 0));
    for (int k = 1; k <= 7; k++) tbl.push_back(vr(k, k == 7, k >= 4));
    tbl.push_back(vr(0, 0, 0));

    do_reset();
    chk("reset.count", int'(count), 0);
    chk("reset.pulse", int'(pulse), 0);
    chk("reset.clkout", int'(clkout), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.div_err", int'(div_err), 0);
    chk("clk_out.high", int'(clk_out), 1);
    @(negedge clk); #1;
    chk("clk_out.low", int'(clk_out), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].md, tbl[i].st, tbl[i].ld, W'(tbl[i].din));
      chk($sformatf("tbl[%0d].count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl[%0d].pulse", i), int'(pulse), int'(tbl[i].p));
      chk($sformatf("tbl[%0d].clkout", i), int'(clkout), int'(tbl[i].c));
      chk($sformatf("tbl[%0d].busy", i), int'(busy), int'(tbl[i].b));
      chk($sformatf("tbl[%0d].div_err", i), int'(div_err), int'(tbl[i].e));
    end

    // Reset mid-period with a divisor pending: abort, then period 6 again.
    do_reset(); rst = 1'b1;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 3);
    tick(1, 0, 0, 0, 0);
    chk("rstab.pre_count", int'(count), 4);
    #2 rst = 1'b0;
    #1;
    chk("rstab.count", int'(count), 0);
    chk("rstab.clkout", int'(clkout), 0);
    chk("rstab.busy", int'(busy), 0);
    chk("rstab.pulse", int'(pulse), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick(1, 0, 0, 0, 0);
      chk($sformatf("rstab.run[%0d].count", k), int'(count), (k + 1) % 6);
      chk($sformatf("rstab.run[%0d].pulse", k), int'(pulse), int'((k + 1) % 6 == 5));
    end

    // One-shot: one period, single pulse, retrigger ignored, then idle at 0.
    do_reset(); rst = 1'b1;
    tick(1, 1, 0, 0, 0);
    chk("os.idle.count", int'(count), 0);
    chk("os.idle.busy", int'(busy), 0);
    tick(1, 1, 1, 0, 0);
    chk("os.start.count", int'(count), 0);
    chk("os.start.busy", int'(busy), 1);
    npulse = int'(pulse);
    for (int k = 1; k <= 5; k++) begin
      tick(1, 1, k == 2, 0, 0);
      npulse += int'(pulse);
      chk($sformatf("os.run[%0d].count", k), int'(count), k);
      chk($sformatf("os.run[%0d].pulse", k), int'(pulse), int'(k == 5));
      chk($sformatf("os.run[%0d].busy", k), int'(busy), 1);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1, 1, 0, 0, 0);
      npulse += int'(pulse);
      chk($sformatf("os.done[%0d].count", k), int'(count), 0);
      chk($sformatf("os.done[%0d].busy", k), int'(busy), 0);
    end
    chk("os.pulse_total", npulse, 1);

    // Continuous -> one-shot mid-period: finishes the period, then stops.
    do_reset(); rst = 1'b1;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick(1, 1, 0, 0, 0);
      chk($sformatf("mchg[%0d].count", k), int'(count), (k <= 2) ? k + 3 : 0);
      chk($sformatf("mchg[%0d].busy", k), int'(busy), int'(k <= 2));
    end

    // Randomized stimulus against the model.
    do_reset(); rst = 1'b1;
    model_reset();
    rmode = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bit e, s, l;
      int dv;
      e  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) rmode = ~rmode;
      s  = ($urandom_range(0, 5) == 0);
      l  = ($urandom_range(0, 9) == 0);
      dv = int'($urandom_range(0, 9));
      tick(e, rmode, s, l, W'(dv));
      model_step(e, rmode, s, l, dv);
      chk($sformatf("rnd[%0d].count", k), int'(count), m_cnt);
      chk($sformatf("rnd[%0d].pulse", k), int'(pulse), int'(e_pulse));
      chk($sformatf("rnd[%0d].clkout", k), int'(clkout), int'(e_clk));
      chk($sformatf("rnd[%0d].busy", k), int'(busy), int'(e_busy));
      chk($sformatf("rnd[%0d].div_err", k), int'(div_err), int'(e_err));
    end

`ifdef PROG_CLK_DIV_DUTY_EN
    do_reset(); rst = 1'b1;
    duty_force = 3;
    tick(0, 0, 0, 1, 10);
    duty_force = -1;
    tick(0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      tick(1, 0, 0, 0, 0);
      chk($sformatf("duty[%0d].count", k), int'(count), (k + 1) % 10);
      chk($sformatf("duty[%0d].clkout", k), int'(clkout), int'((k + 1) % 10 >= 3));
    end
    duty_force = 5;
    tick(1, 0, 0, 1, 5);
    duty_force = -1;
    chk("duty.reject", int'(div_err), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
- Runtime-programmable clock divider for the alarm-clock timebase; next generation of the fixed divide-by-N pulse/clock generator.
- Divides clk by a loadable divisor D in the range 2..2^WIDTH-1 and emits a one-cycle terminal pulse, a near-50% divided clock and the live count.
- Supports continuous and one-shot modes.
- Divisor updates are double-buffered so they never corrupt a period in progress.

Parameters:
- WIDTH, 8, width of counter, divisor and count output.
- DEFAULT_DIV, 6, divisor loaded at reset; must be 2..2^WIDTH-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  count enable; 0 freezes the counter.
- mode  in  1  0 = continuous, 1 = one-shot.
- start  in  1  one-shot trigger, single-cycle; ignored when mode=0.
- div_in  in  WIDTH  new divisor value.
- div_load  in  1  single-cycle strobe; request to load div_in.
- pulse  out  1  high for exactly the cycle in which count == D-1.
- clkout  out  1  divided clock.
- count  out  WIDTH  current counter value.
- busy  out  1  counter is actively running.
- div_err  out  1  one-cycle flag marking a rejected divisor load.
- clk_out  out  1  pass-through of clk.

Behaviour:
- Reset: while rst=0, all state is asynchronously cleared:
  - count=0, pulse=0, clkout=0, busy=0, div_err=0.
  - Active divisor D=DEFAULT_DIV.
  - Shadow register=DEFAULT_DIV, pending=0.
  - One-shot armed flag=0.
- Reset asserted mid-period or mid-one-shot aborts immediately; there is no resume.
- Registered outputs: pulse, clkout and busy are registered and are functions of the count value they accompany.
  - pulse = (count==D-1) && busy.
  - clkout = (count >= D>>1). For D=6: low on counts 0-2, high on counts 3-5. For odd D=5: low on counts 0-1, high on counts 2-4.
- Running condition:
  - Continuous mode: run = en.
  - One-shot mode: run = en && armed.
  - busy = run.
- Counting, on each rising edge with run=1:
  - count increments by 1.
  - When count==D-1 it wraps to 0 on the next edge.
  - No other wrap path exists. Arithmetic is modulo D, never modulo 2^WIDTH.
- en=0: count, clkout and armed all hold; pulse=0.
- One-shot mode:
  - start while not armed sets armed=1 and count=0.
  - The counter runs exactly one period; pulse asserts on count D-1.
  - On the following edge count=0 and armed=0, then the counter holds.
  - start while armed is ignored; no retrigger.
- Mode change while running: takes effect at the next wrap. Until then the counter finishes the current period unchanged.
- Divisor load:
  - div_load with div_in >= 2 writes the shadow register and sets pending=1.
  - div_load with div_in < 2 leaves shadow and pending unchanged and asserts div_err for one cycle.
  - A second valid load before the new divisor is applied overwrites the shadow; the last value wins.
- Divisor apply:
  - While pending=1, D takes the shadow value on the wrap edge, i.e. the edge where count goes D-1 -> 0. pending then clears.
  - If not running, the new divisor is applied on the next edge.
  - div_load coincident with a wrap: the old shadow applies on that edge; the new value is captured and stays pending.
- Latency:
  - First pulse after a continuous start from count 0 appears D cycles later.
  - The one-shot pulse appears on the D-th cycle after start.

Optional Feature:
- Macro: PROG_CLK_DIV_DUTY_EN.
- Defined:
  - Adds input duty_in[WIDTH], captured into a duty shadow on each valid div_load and applied together with D.
  - clkout = (count >= Hth), where Hth is the applied duty threshold and Hth=0 gives a constant-high clkout.
  - A load with duty_in >= div_in is rejected via div_err exactly like div_in < 2.
  - Duty threshold resets to DEFAULT_DIV>>1.
- Undefined: the duty_in port does not exist and the threshold is fixed at D>>1.

Test Plan:
- Reset release, en=1, mode=0, no loads -> count sequence 0,1,2,3,4,5,0; pulse high only on count 5, every 6 cycles; clkout low on counts 0-2 and high on counts 3-5.
- While count=2, div_load with div_in=4 -> current period completes at count 5; next periods run 0..3; pulse every 4 cycles; clkout high on counts 2-3.
- div_load with div_in=1, then with div_in=0 -> div_err high one cycle for each; period remains 6.
- mode=1, start at count 0 -> counts 0..5, single pulse at count 5, busy drops, count holds at 0; a second start during the run has no effect.
- en=0 at count 3 for 5 cycles -> count, clkout and armed hold, pulse=0; counting resumes at count 4 once en returns to 1.
- rst asserted at count 4 with pending=1 -> all outputs 0 immediately and D=6 after release. With PROG_CLK_DIV_DUTY_EN defined: load div_in=10, duty_in=3 -> clkout high on counts 3-9.
